// File: rtl/xor_stream_cipher.sv
// Byte-wise XOR stream cipher with a one-deep output register and a keyed NOKEY/RUN FSM.
// Optional key rotation after each acceptance is enabled by defining XOR_KEY_ROTATE_EN.
module xor_stream_cipher #(
  parameter int N     = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_load,
  input  logic [8*N-1:0]     key_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*N-1:0]     in_chunk,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*N-1:0]     out_chunk,
  output logic [CNT_W-1:0]   chunk_cnt
);

  localparam int W = 8 * N;

  typedef enum logic [0:0] {
    NOKEY = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [W-1:0]       key_q;
  logic [W-1:0]       key_d;
  logic [W-1:0]       out_chunk_q;
  logic [W-1:0]       out_chunk_d;
  logic               out_valid_q;
  logic               out_valid_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               in_ready_s;
  logic               accept_s;

`ifdef XOR_KEY_ROTATE_EN
  // Byte 0 sits in the top byte lane; it moves to the bottom lane and every other byte shifts up.
  function automatic logic [W-1:0] rotl_byte(input logic [W-1:0] k);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      r[W-1-8*i -: 8] = k[W-1-8*((i+1)%N) -: 8];
    end
    return r;
  endfunction
`endif

  // FSM next state and input handshake
  always_comb begin
    state_d    = state_q;
    in_ready_s = 1'b0;
    case (state_q)
      NOKEY: begin
        in_ready_s = 1'b0;
        if (key_load) begin
          state_d = RUN;
        end else begin
          state_d = NOKEY;
        end
      end
      RUN: begin
        // The single output slot can be refilled in the same cycle it drains.
        in_ready_s = !out_valid_q || out_ready;
        state_d    = RUN;
      end
      default: begin
        in_ready_s = 1'b0;
        state_d    = NOKEY;
      end
    endcase
  end

  assign accept_s = in_valid && in_ready_s;

  // Key register: a load wins over rotation, and an accepted chunk always sees key_q
  always_comb begin
    key_d = key_q;
    if (key_load) begin
      key_d = key_in;
    end else if (accept_s) begin
`ifdef XOR_KEY_ROTATE_EN
      key_d = rotl_byte(key_q);
`else
      key_d = key_q;
`endif
    end else begin
      key_d = key_q;
    end
  end

  // Output register and chunk counter
  always_comb begin
    out_chunk_d = out_chunk_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    if (accept_s) begin
      out_chunk_d = in_chunk ^ key_q;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (key_load) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NOKEY;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= {W{1'b0}};
      out_chunk_q <= {W{1'b0}};
      out_valid_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      key_q       <= key_d;
      out_chunk_q <= out_chunk_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_chunk = out_chunk_q;
  assign chunk_cnt = cnt_q;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Randomized and directed bench for xor_stream_cipher against a transaction-level reference model.
module tb_xor_stream_cipher;
  localparam int N     = 2;
  localparam int W     = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             key_load;
  logic [W-1:0]     key_in;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_chunk;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_chunk;
  logic [CNT_W-1:0] chunk_cnt;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // reference model state
  logic         m_loaded;
  logic         m_valid;
  logic [W-1:0] m_key;
  logic [W-1:0] m_out;
  int           m_cnt;
  logic         exp_ready;
  logic         obs_ready;
  logic         m_accept;

  xor_stream_cipher #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_chunk(in_chunk),
    .out_valid(out_valid), .out_ready(out_ready), .out_chunk(out_chunk),
    .chunk_cnt(chunk_cnt)
  );

  always #5 clk = ~clk;

`ifdef XOR_KEY_ROTATE_EN
  function automatic logic [W-1:0] rot_key(input logic [W-1:0] k);
    return {k[7:0], k[15:8]};
  endfunction
`endif

  task automatic model_reset;
    m_loaded = 1'b0; m_valid = 1'b0; m_key = '0; m_out = '0; m_cnt = 0;
  endtask

  // One clock: sample handshake before the edge, advance the model at the edge, settle after.
  task automatic cycle;
    #1;
    obs_ready = in_ready;
    exp_ready = m_loaded && (!m_valid || out_ready);
    m_accept  = in_valid && exp_ready;
    @(posedge clk);
    if (m_accept) m_out = in_chunk ^ m_key;
    if (m_accept) m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    if (key_load && !rst) begin
      m_key = key_in; m_cnt = 0; m_loaded = 1'b1;
    end else if (m_accept) begin
`ifdef XOR_KEY_ROTATE_EN
      m_key = rot_key(m_key);
`endif
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; key_load = 1'b0; key_in = '0; in_valid = 1'b1; in_chunk = 16'h1234; out_ready = 1'b1;
    model_reset();
    cycle(); cycle();
    cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    cmp_cnt++; if (out_chunk !== 16'h0000) begin err_cnt++; $display("FAIL reset_out_chunk got %h want 0000", out_chunk); end
    cmp_cnt++; if (chunk_cnt !== 4'd0) begin err_cnt++; $display("FAIL reset_cnt got %0d want 0", chunk_cnt); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_nokey;
    in_valid = 1'b1; in_chunk = 16'hBEEF; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      cmp_cnt++; if (obs_ready !== 1'b0) begin err_cnt++; $display("FAIL nokey_in_ready got %b want 0", obs_ready); end
      cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL nokey_out_valid got %b want 0", out_valid); end
      cmp_cnt++; if (chunk_cnt !== 4'd0) begin err_cnt++; $display("FAIL nokey_cnt got %0d want 0", chunk_cnt); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_vectors;
    logic [W-1:0] exp2;
`ifdef XOR_KEY_ROTATE_EN
    exp2 = 16'h0E2D;
`else
    exp2 = 16'h2E0D;
`endif
    key_load = 1'b1; key_in = 16'h4868; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    key_load = 1'b0; in_valid = 1'b1; in_chunk = 16'h6665;
    cycle();
    cmp_cnt++; if (obs_ready !== 1'b1) begin err_cnt++; $display("FAIL vec_ready got %b want 1", obs_ready); end
    cmp_cnt++; if (out_chunk !== 16'h2E0D || out_valid !== 1'b1) begin err_cnt++; $display("FAIL vec_first got %h/%b want 2e0d/1", out_chunk, out_valid); end
    cmp_cnt++; if (chunk_cnt !== 4'd1) begin err_cnt++; $display("FAIL vec_cnt1 got %0d want 1", chunk_cnt); end
    cycle();
    cmp_cnt++; if (out_chunk !== exp2 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL vec_second got %h/%b want %h/1", out_chunk, out_valid, exp2); end
    in_valid = 1'b0;
    cycle();
    cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL vec_drain got %b want 0", out_valid); end
    key_load = 1'b1; key_in = 16'h6162;
    cycle();
    key_load = 1'b0; in_valid = 1'b1; in_chunk = 16'h6162;
    cycle();
    cmp_cnt++; if (out_chunk !== 16'h0000 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL vec_self got %h/%b want 0000/1", out_chunk, out_valid); end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_backpressure;
    logic [W-1:0] held;
    in_valid = 1'b1; in_chunk = W'($urandom); out_ready = 1'b0;
    cycle();
    held = m_out;
    cmp_cnt++; if (out_valid !== 1'b1 || out_chunk !== held) begin err_cnt++; $display("FAIL bp_first got %h/%b want %h/1", out_chunk, out_valid, held); end
    for (int i = 0; i < 3; i++) begin
      in_chunk = W'($urandom);
      cycle();
      cmp_cnt++; if (obs_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_ready got %b want 0", obs_ready); end
      cmp_cnt++; if (out_chunk !== held || out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_hold got %h/%b want %h/1", out_chunk, out_valid, held); end
    end
    out_ready = 1'b1; in_chunk = 16'h5A5A;
    cycle();
    cmp_cnt++; if (obs_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_release_ready got %b want 1", obs_ready); end
    cmp_cnt++; if (out_chunk !== m_out || out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_release got %h/%b want %h/1", out_chunk, out_valid, m_out); end
    cmp_cnt++; if (chunk_cnt !== m_cnt[CNT_W-1:0]) begin err_cnt++; $display("FAIL bp_cnt got %0d want %0d", chunk_cnt, m_cnt); end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      key_load  = ($urandom_range(0, 15) == 0);
      key_in    = W'($urandom);
      in_valid  = 1'($urandom);
      in_chunk  = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      cmp_cnt++; if (obs_ready !== exp_ready) begin err_cnt++; $display("FAIL rnd_ready i=%0d got %b want %b", i, obs_ready, exp_ready); end
      cmp_cnt++; if (out_valid !== m_valid) begin err_cnt++; $display("FAIL rnd_valid i=%0d got %b want %b", i, out_valid, m_valid); end
      if (m_valid) begin
        cmp_cnt++; if (out_chunk !== m_out) begin err_cnt++; $display("FAIL rnd_chunk i=%0d got %h want %h", i, out_chunk, m_out); end
      end
      cmp_cnt++; if (chunk_cnt !== m_cnt[CNT_W-1:0]) begin err_cnt++; $display("FAIL rnd_cnt i=%0d got %0d want %0d", i, chunk_cnt, m_cnt); end
    end
    key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_wrap;
    logic [W-1:0] old_key;
    logic [W-1:0] new_key;
    logic [W-1:0] c;
    key_load = 1'b1; key_in = 16'hC3A5; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    key_load = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_chunk = W'($urandom);
      cycle();
      cmp_cnt++; if (out_chunk !== m_out) begin err_cnt++; $display("FAIL wrap_chunk i=%0d got %h want %h", i, out_chunk, m_out); end
    end
    cmp_cnt++; if (chunk_cnt !== 4'd1) begin err_cnt++; $display("FAIL wrap_cnt got %0d want 1", chunk_cnt); end
    old_key = m_key; new_key = 16'h0F1E; c = 16'h7733;
    key_load = 1'b1; key_in = new_key; in_chunk = c;
    cycle();
    cmp_cnt++; if (chunk_cnt !== 4'd0) begin err_cnt++; $display("FAIL wrap_load_cnt got %0d want 0", chunk_cnt); end
    cmp_cnt++; if (out_chunk !== (c ^ old_key)) begin err_cnt++; $display("FAIL wrap_oldkey got %h want %h", out_chunk, c ^ old_key); end
    key_load = 1'b0; c = 16'h1248; in_chunk = c;
    cycle();
    cmp_cnt++; if (out_chunk !== (c ^ new_key)) begin err_cnt++; $display("FAIL wrap_newkey got %h want %h", out_chunk, c ^ new_key); end
    cmp_cnt++; if (chunk_cnt !== 4'd1) begin err_cnt++; $display("FAIL wrap_after_cnt got %0d want 1", chunk_cnt); end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_reset_midop;
    key_load = 1'b1; key_in = 16'h9999; in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    key_load = 1'b0; in_valid = 1'b1; in_chunk = 16'h1111;
    cycle();
    cmp_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    cmp_cnt++; if (out_valid !== 1'b0 || out_chunk !== 16'h0000) begin err_cnt++; $display("FAIL mid_async got %h/%b want 0000/0", out_chunk, out_valid); end
    cmp_cnt++; if (in_ready !== 1'b0 || chunk_cnt !== 4'd0) begin err_cnt++; $display("FAIL mid_async_ctl got %b/%0d want 0/0", in_ready, chunk_cnt); end
    model_reset();
    cycle();
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_chunk = 16'h2222;
    cycle();
    cmp_cnt++; if (obs_ready !== 1'b0 || out_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_needs_key got %b/%b want 0/0", obs_ready, out_valid); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nokey();
    test_vectors();
    test_backpressure();
    test_random();
    test_wrap();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/xor_stream_cipher.md
XOR_STREAM_CIPHER -- requirements
Module: xor_stream_cipher

Interface
- REQ-001: Parameter N SHALL be 2 by default and sets the chunk width in bytes (data/key width 8*N, N >= 1).
- REQ-002: Parameter CNT_W SHALL be 16 by default and sets the width of the chunk counter.
- REQ-003: Port clk SHALL be an input, 1 bit: the single clock; all state updates occur on its rising edge.
- REQ-004: Port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
- REQ-005: Port key_load SHALL be an input, 1 bit: when 1, key_in is loaded into the key register.
- REQ-006: Port key_in SHALL be an input, 8*N bits: the new key value.
- REQ-007: Port in_valid SHALL be an input, 1 bit: the upstream chunk is valid.
- REQ-008: Port in_ready SHALL be an output, 1 bit: the block accepts a chunk this cycle.
- REQ-009: Port in_chunk SHALL be an input, 8*N bits: the plaintext or ciphertext chunk; byte 0 is in [8*N-1:8*N-8].
- REQ-010: Port out_valid SHALL be an output, 1 bit: out_chunk holds a result.
- REQ-011: Port out_ready SHALL be an input, 1 bit: downstream accepts the result.
- REQ-012: Port out_chunk SHALL be an output, 8*N bits: the result in_chunk XOR key.
- REQ-013: Port chunk_cnt SHALL be an output, CNT_W bits: the number of chunks accepted since reset or the last key_load.

Function
- REQ-014: The FSM SHALL have two states: NOKEY (the reset state) and RUN.
- REQ-015: NOKEY SHALL force in_ready=0 and move to RUN on the clock edge where key_load=1.
- REQ-016: RUN SHALL hold indefinitely, and key_load in RUN SHALL reload the key without leaving RUN.
- REQ-017: In RUN, in_ready SHALL equal (!out_valid || out_ready), giving a single output register with no bubble at full throughput.
- REQ-018: A chunk SHALL be accepted when in_valid && in_ready; its result SHALL appear in out_chunk with out_valid=1 on the following cycle (latency 1).
- REQ-019: out_chunk SHALL be computed as the bytewise XOR of in_chunk and the key register value current in the acceptance cycle.
- REQ-020: out_valid SHALL clear on a cycle where out_ready=1 and no new chunk is accepted.
- REQ-021: out_chunk and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
- REQ-022: If key_load and chunk acceptance coincide, the accepted chunk SHALL use the old key; the new key SHALL apply from the next acceptance.
- REQ-023: chunk_cnt SHALL increment by 1 per accepted chunk and wrap from 2^CNT_W-1 to 0.
- REQ-024: key_load SHALL reset chunk_cnt to 0; if key_load coincides with an acceptance, chunk_cnt SHALL become 0, not 1.
- REQ-025: key_load SHALL NOT flush a pending output; out_valid/out_chunk are unaffected.

Reset
- REQ-026: While rst=1, regardless of clk, the block SHALL set: state=NOKEY, key register=0, out_valid=0, out_chunk=0, chunk_cnt=0, in_ready=0.
- REQ-027: An output held when reset asserts mid-operation SHALL be discarded, and a key SHALL be reloaded before any chunk is accepted.

Configuration
- REQ-028: When macro XOR_KEY_ROTATE_EN is defined, each acceptance without a simultaneous key_load SHALL rotate the key register left by 8 bits (byte 0 moves to the last position) after use.
- REQ-029: When XOR_KEY_ROTATE_EN is undefined, the key register SHALL change only on key_load.
- REQ-030: With XOR_KEY_ROTATE_EN defined and key_load coinciding with an acceptance, key_in SHALL be loaded unrotated.

Verification (N=2)
- REQ-031: Reset, then in_valid=1 before any key_load -> in_ready=0, out_valid=0, chunk_cnt=0.
- REQ-032: key_in=16'h4868 ("Hh") loaded, then chunk 16'h6665 ("fe") -> next cycle out_chunk=16'h2E0D, out_valid=1, chunk_cnt=1.
- REQ-033: key 16'h6162 ("ab"), chunk 16'h6162 -> out_chunk=16'h0000.
- REQ-034: XOR_KEY_ROTATE_EN defined, key 16'h4868, chunks 16'h6665 then 16'h6665 back-to-back -> outputs 16'h2E0D then 16'h0E2D; undefined -> 16'h2E0D twice.
- REQ-035: Hold out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_chunk stable; then out_ready=1 with in_valid=1 -> accept in the same cycle with no bubble.
- REQ-036: With CNT_W=4, accept 17 chunks -> chunk_cnt=1; then key_load together with an acceptance -> chunk_cnt=0 and that chunk uses the old key.
